// File: rtl/std_mem_d1_arb.sv
// Round-robin arbiter sharing one std_mem_d1 between two go/done requesters.
// One access in flight at a time; operands are latched at grant.
//
// state | meaning
// IDLE  | sample go inputs and grant one requester
// READ  | present latched address, capture memory read data for owner
// WRITE | drive mem_write_en for exactly one cycle
// WAIT  | hold until the memory reports done
// RESP  | pulse the owner's done
module std_mem_d1_arb #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_go,
  input  logic [IDX_SIZE-1:0] req0_addr,
  input  logic [WIDTH-1:0]    req0_write_data,
  input  logic                req0_write_en,
  output logic [WIDTH-1:0]    req0_read_data,
  output logic                req0_done,
  input  logic                req1_go,
  input  logic [IDX_SIZE-1:0] req1_addr,
  input  logic [WIDTH-1:0]    req1_write_data,
  input  logic                req1_write_en,
  output logic [WIDTH-1:0]    req1_read_data,
  output logic                req1_done,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_read_data,
  input  logic                mem_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]          state;
  logic                owner;
  logic                prio;
  logic [IDX_SIZE-1:0] lat_addr;
  logic [WIDTH-1:0]    lat_data;
  logic                lat_we;

  logic                any_go;
  logic                win;

  // A lone requester wins outright; prio only breaks ties.
  always_comb begin
    any_go = req0_go | req1_go;
    win    = (req0_go && req1_go) ? prio : req1_go;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= 1'b0;
      prio           <= 1'b0;
      lat_addr       <= '0;
      lat_data       <= '0;
      lat_we         <= 1'b0;
      req0_read_data <= '0;
      req1_read_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_go) begin
            owner    <= win;
            prio     <= ~win;
            lat_addr <= win ? req1_addr       : req0_addr;
            lat_data <= win ? req1_write_data : req0_write_data;
            lat_we   <= win ? req1_write_en   : req0_write_en;
            state    <= (win ? req1_write_en : req0_write_en) ? WRITE : READ;
          end
        end
        READ: begin
          if (owner) req1_read_data <= mem_read_data;
          else       req0_read_data <= mem_read_data;
          state <= RESP;
        end
        WRITE: state <= WAIT;
        WAIT: begin
          if (mem_done) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr0      = lat_addr;
  assign mem_write_data = lat_data;
  assign mem_write_en   = (state == WRITE);
  assign req0_done      = (state == RESP) && !owner;
  assign req1_done      = (state == RESP) && owner;

endmodule

// File: tb/tb_std_mem_d1_arb.sv
// Randomized bench for std_mem_d1_arb: a transaction-level model predicts grants,
// done timing, write strobes and read data; the memory has a per-write random latency.
module tb_std_mem_d1_arb;
  localparam int W = 32;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_go, req0_write_en, req1_go, req1_write_en;
  logic [A-1:0] req0_addr, req1_addr, mem_addr0;
  logic [W-1:0] req0_write_data, req1_write_data;
  logic [W-1:0] req0_read_data, req1_read_data, mem_write_data, mem_read_data;
  logic         req0_done, req1_done, mem_write_en, mem_done;

  std_mem_d1_arb #(.WIDTH(W), .IDX_SIZE(A)) dut (
    .clk(clk), .reset(reset),
    .req0_go(req0_go), .req0_addr(req0_addr), .req0_write_data(req0_write_data),
    .req0_write_en(req0_write_en), .req0_read_data(req0_read_data), .req0_done(req0_done),
    .req1_go(req1_go), .req1_addr(req1_addr), .req1_write_data(req1_write_data),
    .req1_write_en(req1_write_en), .req1_read_data(req1_read_data), .req1_done(req1_done),
    .mem_addr0(mem_addr0), .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_data(mem_read_data), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  // requester drive state
  logic         g [2];
  logic [A-1:0] a [2];
  logic [W-1:0] d [2];
  logic         w [2];
  assign req0_go = g[0]; assign req0_addr = a[0]; assign req0_write_data = d[0]; assign req0_write_en = w[0];
  assign req1_go = g[1]; assign req1_addr = a[1]; assign req1_write_data = d[1]; assign req1_write_en = w[1];

  // memory: combinational read, write on clock, done mem_lat cycles after write_en
  logic [W-1:0] mem [16];
  logic         mem_init;
  int           mem_lat;
  int           dcnt;
  logic [31:0]  seed;

  function automatic logic [W-1:0] init_val(input int i);
    return seed ^ (i * 32'h9E3779B9);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (mem_write_en) begin
      mem[mem_addr0] <= mem_write_data;
    end
    if (reset)             dcnt <= 0;
    else if (mem_write_en) dcnt <= mem_lat;
    else if (dcnt != 0)    dcnt <= dcnt - 1;
  end
  assign mem_read_data = mem[mem_addr0];
  assign mem_done      = (dcnt == 1);

  // reference model
  logic [W-1:0] ref_mem [16];
  logic [W-1:0] ref_rd [2];
  bit           busy, prio, t_owner, t_we, win;
  int           t_c0, t_done, lat;
  logic [A-1:0] t_addr;
  logic [W-1:0] t_data, t_rdval;

  int  cyc, vectors, errors, rst_cnt;
  bit  want_reset, exp_we;
  bit  dn [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done0"}, {31'd0, req0_done}, 32'd0);
    chk({tag, "_done1"}, {31'd0, req1_done}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_write_en}, 32'd0);
    chk({tag, "_rd0"},   req0_read_data, 32'd0);
    chk({tag, "_rd1"},   req1_read_data, 32'd0);
  endtask

  task automatic new_op(input int n);
    a[n] = A'($urandom_range(0, 7));
    d[n] = $urandom;
    w[n] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    seed     = $urandom;
    reset    = 1'b1;
    mem_init = 1'b1;
    mem_lat  = 1;
    for (int n = 0; n < 2; n++) begin
      g[n] = 1'b0; a[n] = '0; d[n] = '0; w[n] = 1'b0;
      ref_rd[n] = '0;
    end
    vectors = 0; errors = 0; cyc = 0; rst_cnt = 0; want_reset = 0;
    busy = 0; prio = 0;
    #1;
    chk_zero("reset");
    chk("reset_addr", {28'd0, mem_addr0}, 32'd0);
    chk("reset_wdata", mem_write_data, 32'd0);
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    reset    = 1'b0;

    for (int it = 0; it < 4000; it++) begin
      @(negedge clk);
      cyc++;
      if (it == 1300 || it == 2700) want_reset = 1;

      if (rst_cnt > 0) begin
        chk_zero("in_reset");
        rst_cnt--;
        if (rst_cnt > 0) continue;
        reset = 1'b0;
      end else begin
        if (busy && !t_we && cyc == t_done) ref_rd[t_owner] = t_rdval;
        exp_we = busy && t_we && (cyc == t_c0 + 1);
        chk("done0", {31'd0, req0_done}, {31'd0, busy && cyc == t_done && !t_owner});
        chk("done1", {31'd0, req1_done}, {31'd0, busy && cyc == t_done && t_owner});
        chk("mem_we", {31'd0, mem_write_en}, {31'd0, exp_we});
        if (exp_we) begin
          chk("wr_addr", {28'd0, mem_addr0}, {28'd0, t_addr});
          chk("wr_data", mem_write_data, t_data);
        end
        chk("rd0", req0_read_data, ref_rd[0]);
        chk("rd1", req1_read_data, ref_rd[1]);

        // abandon a write while it waits for the memory
        if (want_reset && busy && t_we && cyc >= t_c0 + 2 && cyc < t_done) begin
          reset = 1'b1;
          #1;
          chk_zero("async_rst");
          chk("async_rst_addr", {28'd0, mem_addr0}, 32'd0);
          chk("async_rst_wdata", mem_write_data, 32'd0);
          g[0] = 1'b0; g[1] = 1'b0;
          busy = 0; prio = 0;
          ref_rd[0] = '0; ref_rd[1] = '0;
          rst_cnt = 2;
          want_reset = 0;
          continue;
        end
      end

      dn[0] = req0_done;
      dn[1] = req1_done;
      for (int n = 0; n < 2; n++) begin
        if (g[n] && dn[n]) begin
          if ($urandom_range(0, 1) == 1) g[n] = 1'b0;
          else new_op(n);
        end else if (!g[n] && $urandom_range(0, 99) < 30) begin
          g[n] = 1'b1;
          new_op(n);
        end
      end

      if (!busy && (g[0] || g[1])) begin
        win     = (g[0] && g[1]) ? prio : g[1];
        prio    = ~win;
        busy    = 1;
        t_owner = win;
        t_addr  = a[win];
        t_data  = d[win];
        t_we    = w[win];
        t_c0    = cyc;
        if (t_we) begin
          lat     = $urandom_range(1, 5);
          mem_lat = lat;
          t_done  = cyc + 2 + lat;
          ref_mem[t_addr] = t_data;
        end else begin
          t_done  = cyc + 2;
          t_rdval = ref_mem[t_addr];
        end
      end else if (busy && cyc == t_done) begin
        busy = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/std_mem_d1_arb.md
Name: std_mem_d1_arb

Overview:
Two-requester round-robin arbiter that shares one std_mem_d1 instance between two Calyx components or groups.
- Each requester sees a go/done memory port with a registered read_data.
- The arbiter serialises accesses and drives the memory's addr0/write_data/write_en.
- It waits on the memory's done for writes.
- It sits between the requesters and the memory, inside the generated component.

Parameters:
WIDTH, 32, data width of memory words and of read/write data ports
IDX_SIZE, 4, address width (matches memory IDX_SIZE)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req0_go  input  1  requester 0 access request; held high with stable operands until req0_done
req0_addr  input  IDX_SIZE  requester 0 address
req0_write_data  input  WIDTH  requester 0 write data
req0_write_en  input  1  1 = write, 0 = read
req0_read_data  output  WIDTH  registered read result for requester 0
req0_done  output  1  one-cycle completion pulse for requester 0
req1_go, req1_addr, req1_write_data, req1_write_en, req1_read_data, req1_done  same directions/widths/meanings for requester 1
mem_addr0  output  IDX_SIZE  to memory addr0
mem_write_data  output  WIDTH  to memory write_data
mem_write_en  output  1  to memory write_en
mem_read_data  input  WIDTH  from memory read_data (combinational read)
mem_done  input  1  from memory done

Behaviour:
- Reset (async, active-high):
  - state=IDLE, prio=0, owner=0.
  - Latched addr/data/we = 0.
  - reqN_read_data = 0, reqN_done = 0, mem_write_en = 0.
- State registers: state, owner (1b), prio (1b), lat_addr, lat_data, lat_we.
- mem_addr0 = lat_addr and mem_write_data = lat_data at all times; mem_write_en = (state==WRITE).
- IDLE:
  - go inputs are sampled only in IDLE.
  - If exactly one reqN_go=1, grant N.
  - If both are high, grant prio.
  - On grant: owner<=N, prio<=~N; latch reqN_addr/write_data/write_en; next = WRITE if write_en else READ.
  - With no go, stay in IDLE.
- READ (1 cycle): mem_addr0 = lat_addr; reqOwner_read_data <= mem_read_data; next RESP.
- WRITE (1 cycle): mem_write_en=1 exactly one cycle; next WAIT.
- WAIT:
  - Hold until mem_done=1, then RESP.
  - mem_done arriving in the WRITE cycle is ignored; only WAIT observes it.
  - No timeout.
- RESP (1 cycle): reqOwner_done=1, the other done=0; next IDLE.
- Latency from the go-sampled edge (cycle 0 = IDLE with go high):
  - Read: done high in cycle 2.
  - Write: done high in cycle 3, with a standard memory whose done follows write_en by one cycle.
- Go/done rules:
  - go still high in the RESP cycle is not resampled.
  - go still high on return to IDLE is treated as a new request.
- Round-robin: a lone requester always wins regardless of prio. Back-to-back contention alternates 0,1,0,1.
- reqN_read_data holds its value until that requester's next read. Writes and the other requester's reads never change it.
- reqN_done is never high for both requesters in the same cycle; at most one access is in flight.
- Operands are latched at grant, so requester changes after grant do not affect the access.
- Reset mid-access:
  - Everything returns to reset values immediately and mem_write_en drops.
  - The in-flight access is abandoned with no done.
  - A write in progress at the reset edge may or may not land in memory.
- Addresses are not range-checked; the memory owns that.

Test Plan:
1. Read, single requester: preload mem[3]=0xDEADBEEF; req0_go=1, addr=3, write_en=0 -> req0_done pulses 2 cycles after grant; req0_read_data=0xDEADBEEF; req1_done stays 0.
2. Write then read: req1 writes 0x12345678 to addr 5 -> mem_write_en high exactly 1 cycle with mem_addr0=5; req1_done 3 cycles after grant; req1 then reads addr 5 -> 0x12345678.
3. Contention: after reset, both go in the same cycle (req0 read addr1, req1 write addr2) -> req0 is served first; req1 is granted in the IDLE cycle after req0_done; with both held high, the next grants alternate 1,0.
4. Isolation: req0 reads 0xAAAA, then req1 reads 0x5555 and writes -> req0_read_data stays 0xAAAA throughout.
5. Slow memory: mem_done delayed 4 cycles after write_en -> arbiter holds WAIT; mem_write_en stays 0 after its 1 cycle; req0_done appears exactly 1 cycle after mem_done.
6. Reset mid-write: assert reset during WAIT -> all outputs 0 asynchronously; no done pulse; after release a new req1 read is granted with prio=0 semantics (req0 wins a tie).
